// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/phase encodings and strobe bundle for the cpu sequencer
package cpu_pkg;

  // Instruction opcodes as held in the IR
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Sequencer phases, one per clock, wrapping STORE -> INST_ADDR
  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  // All datapath strobes driven by the sequencer
  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
  } strobe_t;

  localparam strobe_t STROBE_NONE = '0;

  // Opcodes that read an operand from memory into the accumulator path
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// rtl/cpu_seq_decode.sv - combinational map from phase, opcode and zero flag to datapath strobes
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  logic [2:0] phase,
  input  logic [2:0] opcode,
  input  logic       zero,
  output strobe_t    strobes
);

  logic aluop;
  assign aluop = is_aluop(opcode);

  // Per-phase strobe decode; ungated, the top applies reset/load/halt/enable gating
  always_comb begin
    strobes = STROBE_NONE;
    case (phase)
      PH_INST_ADDR: begin
        strobes.sel = 1'b1;
      end
      PH_INST_FETCH: begin
        strobes.sel = 1'b1;
        strobes.rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        strobes.sel   = 1'b1;
        strobes.rd    = 1'b1;
        strobes.ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        strobes.inc_pc = (opcode != OP_HLT);
      end
      PH_OP_FETCH: begin
        strobes.rd = aluop;
      end
      PH_ALU_OP: begin
        strobes.rd     = aluop;
        strobes.inc_pc = (opcode == OP_SKZ) && zero;
        strobes.ld_pc  = (opcode == OP_JMP);
        strobes.data_e = (opcode == OP_STO);
      end
      PH_STORE: begin
        strobes.rd     = aluop;
        strobes.ld_ac  = aluop;
        strobes.ld_pc  = (opcode == OP_JMP);
        strobes.inc_pc = (opcode == OP_JMP);
        strobes.wr     = (opcode == OP_STO);
        strobes.data_e = (opcode == OP_STO);
      end
      default: begin
        strobes = STROBE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - eight-phase cpu control sequencer; optional single-step via CPU_SEQ_STEP_EN
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load_in,
  input  logic       en_cpu,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef CPU_SEQ_STEP_EN
  input  logic       step,
`endif
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       halt,
  output logic       instr_done
);

  logic [2:0] phase_q;
  logic       halt_q;
  logic       step_ok;
  logic       running;
  logic       halting;
  logic       step_wait;
  logic       advance;
  logic       gated;
  strobe_t    dec_strobes;
  strobe_t    out_strobes;

`ifdef CPU_SEQ_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  // Sequencer may move only when not loading, not halted and enabled
  assign running   = !load_in && !halt_q && en_cpu;
  // HLT is caught in OP_ADDR: the phase parks there and the halt flag is set
  assign halting   = (phase_q == PH_OP_ADDR) && (opcode == OP_HLT);
  // With single-step, INST_ADDR waits for a step request
  assign step_wait = (phase_q == PH_INST_ADDR) && !step_ok;
  assign advance   = running && !halting && !step_wait;
  // Any of reset, load, halt or disable silences every strobe, including sel
  assign gated     = reset || !running;

  cpu_seq_decode u_decode (
    .phase   (phase_q),
    .opcode  (opcode),
    .zero    (zero),
    .strobes (dec_strobes)
  );

  assign out_strobes = gated ? STROBE_NONE : dec_strobes;

  assign sel    = out_strobes.sel;
  assign rd     = out_strobes.rd;
  assign wr     = out_strobes.wr;
  assign ld_ir  = out_strobes.ld_ir;
  assign inc_pc = out_strobes.inc_pc;
  assign ld_pc  = out_strobes.ld_pc;
  assign data_e = out_strobes.data_e;
  assign ld_ac  = out_strobes.ld_ac;

  assign phase      = phase_q;
  assign halt       = halt_q;
  assign instr_done = !reset && advance && (phase_q == PH_STORE);

  // Phase counter and halt flag, priority reset > load > halt > disable > advance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= PH_INST_ADDR;
      halt_q  <= 1'b0;
    end else if (load_in) begin
      phase_q <= PH_INST_ADDR;
      halt_q  <= 1'b0;
    end else if (halt_q || !en_cpu) begin
      phase_q <= phase_q;
    end else if (halting) begin
      halt_q  <= 1'b1;
    end else if (advance) begin
      phase_q <= phase_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer with a behavioural model
module tb_cpu_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_in = 1'b0;
  logic       en_cpu = 1'b1;
  logic [2:0] opcode = 3'b010;
  logic       zero = 1'b0;
  logic       step = 1'b1;
  logic [2:0] phase;
  logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, data_e, ld_ac, halt, instr_done;

  int total = 0;
  int bad = 0;

  cpu_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .load_in    (load_in),
    .en_cpu     (en_cpu),
    .opcode     (opcode),
    .zero       (zero),
`ifdef CPU_SEQ_STEP_EN
    .step       (step),
`endif
    .phase      (phase),
    .sel        (sel),
    .rd         (rd),
    .wr         (wr),
    .ld_ir      (ld_ir),
    .inc_pc     (inc_pc),
    .ld_pc      (ld_pc),
    .data_e     (data_e),
    .ld_ac      (ld_ac),
    .halt       (halt),
    .instr_done (instr_done)
  );

  always #5 clock = ~clock;

  // Behavioural model state: phase as an integer and a halted flag
  int   m_phase = 0;
  logic m_halt = 1'b0;
  logic step_mode;
`ifdef CPU_SEQ_STEP_EN
  assign step_mode = 1'b1;
`else
  assign step_mode = 1'b0;
`endif

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_halt  <= 1'b0;
    end else if (load_in) begin
      m_phase <= 0;
      m_halt  <= 1'b0;
    end else if (m_halt || !en_cpu) begin
      m_phase <= m_phase;
    end else if (m_phase == 4 && opcode == 3'b000) begin
      m_halt <= 1'b1;
    end else if (step_mode && m_phase == 0 && !step) begin
      m_phase <= m_phase;
    end else begin
      m_phase <= (m_phase + 1) % 8;
    end
  end

  // Expected strobes {sel,rd,wr,ld_ir,inc_pc,ld_pc,data_e,ld_ac} from the phase rules
  function automatic logic [7:0] exp_strobes(input int ph, input logic [2:0] op, input logic z);
    logic alu, e_sel, e_rd, e_wr, e_ir, e_inc, e_ldpc, e_de, e_ac;
    alu    = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    e_sel  = (ph <= 3);
    e_rd   = (ph >= 1 && ph <= 3) || (alu && ph >= 5);
    e_wr   = (op == 3'd6) && (ph == 7);
    e_ir   = (ph == 2) || (ph == 3);
    e_inc  = (ph == 4 && op != 3'd0) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
    e_ldpc = (op == 3'd7) && (ph == 6 || ph == 7);
    e_de   = (op == 3'd6) && (ph == 6 || ph == 7);
    e_ac   = alu && (ph == 7);
    return {e_sel, e_rd, e_wr, e_ir, e_inc, e_ldpc, e_de, e_ac};
  endfunction

  function automatic logic [7:0] dut_strobes();
    return {sel, rd, wr, ld_ir, inc_pc, ld_pc, data_e, ld_ac};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT against the model, away from the rising edge
  always @(negedge clock) begin
    logic gated;
    logic [7:0] es;
    gated = reset || load_in || m_halt || !en_cpu;
    es = gated ? 8'h00 : exp_strobes(m_phase, opcode, zero);
    check("model_phase", {29'd0, phase}, m_phase);
    check("model_halt", {31'd0, halt}, {31'd0, m_halt});
    check("model_strobes", {24'd0, dut_strobes()}, {24'd0, es});
    check("model_instr_done", {31'd0, instr_done}, {31'd0, (m_phase == 7) && !gated});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one 8-cycle instruction from INST_ADDR, collecting per-phase strobe bitmaps
  task automatic run_instr(input logic [2:0] op, input logic z,
                           output logic [7:0] p_rd, output logic [7:0] p_ir,
                           output logic [7:0] p_inc, output logic [7:0] p_ldpc,
                           output logic [7:0] p_de, output logic [7:0] p_wr,
                           output logic [7:0] p_ac, output logic [7:0] p_done);
    opcode = op;
    zero   = z;
    p_rd = '0; p_ir = '0; p_inc = '0; p_ldpc = '0;
    p_de = '0; p_wr = '0; p_ac = '0; p_done = '0;
    #1;
    check("instr_start_phase", {29'd0, phase}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      p_rd[phase]   = rd;
      p_ir[phase]   = ld_ir;
      p_inc[phase]  = inc_pc;
      p_ldpc[phase] = ld_pc;
      p_de[phase]   = data_e;
      p_wr[phase]   = wr;
      p_ac[phase]   = ld_ac;
      p_done[phase] = instr_done;
      tick();
    end
  endtask

  logic [7:0] p_rd, p_ir, p_inc, p_ldpc, p_de, p_wr, p_ac, p_done;

  initial begin
    // Reset held for a few cycles
    tick(); tick();
    check("reset_phase", {29'd0, phase}, 32'd0);
    check("reset_halt", {31'd0, halt}, 32'd0);
    check("reset_done", {31'd0, instr_done}, 32'd0);
    check("reset_strobes", {24'd0, dut_strobes()}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_reset_sel", {31'd0, sel}, 32'd1);

    // ADD
    run_instr(3'b010, 1'b0, p_rd, p_ir, p_inc, p_ldpc, p_de, p_wr, p_ac, p_done);
    check("add_rd", {24'd0, p_rd}, 32'b1110_1110);
    check("add_ld_ir", {24'd0, p_ir}, 32'b0000_1100);
    check("add_inc_pc", {24'd0, p_inc}, 32'b0001_0000);
    check("add_ld_ac", {24'd0, p_ac}, 32'b1000_0000);
    check("add_done", {24'd0, p_done}, 32'b1000_0000);

    // SKZ with zero set and clear
    run_instr(3'b001, 1'b1, p_rd, p_ir, p_inc, p_ldpc, p_de, p_wr, p_ac, p_done);
    check("skz_z1_inc_pc", {24'd0, p_inc}, 32'b0101_0000);
    check("skz_z1_rd", {24'd0, p_rd}, 32'b0000_1110);
    run_instr(3'b001, 1'b0, p_rd, p_ir, p_inc, p_ldpc, p_de, p_wr, p_ac, p_done);
    check("skz_z0_inc_pc", {24'd0, p_inc}, 32'b0001_0000);

    // STO
    run_instr(3'b110, 1'b0, p_rd, p_ir, p_inc, p_ldpc, p_de, p_wr, p_ac, p_done);
    check("sto_data_e", {24'd0, p_de}, 32'b1100_0000);
    check("sto_wr", {24'd0, p_wr}, 32'b1000_0000);
    check("sto_ld_ac", {24'd0, p_ac}, 32'b0000_0000);

    // JMP
    run_instr(3'b111, 1'b0, p_rd, p_ir, p_inc, p_ldpc, p_de, p_wr, p_ac, p_done);
    check("jmp_ld_pc", {24'd0, p_ldpc}, 32'b1100_0000);
    check("jmp_inc_pc", {24'd0, p_inc}, 32'b1001_0000);

    // en_cpu low for 3 cycles at phase 2
    opcode = 3'b011;
    tick(); tick();
    check("en_hold_start", {29'd0, phase}, 32'd2);
    en_cpu = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en_hold_strobes", {24'd0, dut_strobes()}, 32'd0);
      tick();
      check("en_hold_phase", {29'd0, phase}, 32'd2);
    end
    en_cpu = 1'b1;
    #1;
    check("en_resume_strobes", {24'd0, dut_strobes()}, 32'b1101_0000);
    tick();
    check("en_resume_phase", {29'd0, phase}, 32'd3);

    // Asynchronous reset in the middle of phase 5
    tick(); tick();
    check("mid_reset_pre", {29'd0, phase}, 32'd5);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_phase", {29'd0, phase}, 32'd0);
    check("mid_reset_strobes", {24'd0, dut_strobes()}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_reset_sel", {31'd0, sel}, 32'd1);

    // HLT parks at phase 4 until load_in
    opcode = 3'b000;
    tick(); tick(); tick(); tick();
    check("hlt_phase4", {29'd0, phase}, 32'd4);
    check("hlt_no_inc", {31'd0, inc_pc}, 32'd0);
    tick();
    check("hlt_set", {31'd0, halt}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hlt_frozen", {29'd0, phase}, 32'd4);
      check("hlt_quiet", {24'd0, dut_strobes()}, 32'd0);
    end
    load_in = 1'b1;
    tick();
    check("load_phase", {29'd0, phase}, 32'd0);
    check("load_halt", {31'd0, halt}, 32'd0);
    check("load_sel", {31'd0, sel}, 32'd0);
    load_in = 1'b0;
    opcode = 3'b010;
    #1;
    check("load_drop_sel", {31'd0, sel}, 32'd1);
    tick();
    check("load_drop_advance", {29'd0, phase}, 32'd1);

`ifdef CPU_SEQ_STEP_EN
    // Single-step: INST_ADDR waits for step
    for (int i = 0; i < 7; i++) tick();
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("step_wait_phase", {29'd0, phase}, 32'd0);
      check("step_wait_strobes", {24'd0, dut_strobes()}, 32'b1000_0000);
      tick();
    end
    step = 1'b1;
    tick();
    check("step_go_phase", {29'd0, phase}, 32'd1);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Eight-phase control sequencer for the 8-bit RISC CPU. It owns a 3-bit phase counter, decodes the 3-bit opcode from the instruction register, and drives all datapath strobes: PC increment/load, memory read/write, IR/accumulator load, and address-mux select. It sits between the instruction register and the program counter, accumulator and memory. It also handles load-mode, CPU-enable gating and HLT.

## Interface
Parameters:
- none. All encodings come from the shared package.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- load_in  in  1  program-load mode. While high, the sequencer holds at INST_ADDR.
- en_cpu  in  1  execution enable. When low, the phase freezes.
- opcode  in  3  current IR opcode: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- zero  in  1  accumulator-is-zero flag.
- step  in  1  single-step advance. Present only with CPU_SEQ_STEP_EN.
- phase  out  3  current phase, 0..7.
- sel  out  1  address mux select: 1 selects PC, 0 selects IR operand.
- rd  out  1  memory read.
- wr  out  1  memory write.
- ld_ir  out  1  instruction register load.
- inc_pc  out  1  PC increment.
- ld_pc  out  1  PC load from IR operand.
- data_e  out  1  accumulator drives the data bus.
- ld_ac  out  1  accumulator load.
- halt  out  1  CPU halted, registered.
- instr_done  out  1  one-cycle pulse in STORE when the phase advances.

## Operation
- Phases, in order: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7). The counter wraps 7->0.
- ALUOP denotes opcode in {ADD, AND, XOR, LDA}.
- Strobes are decoded combinationally from phase, opcode and zero:
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD and IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc if opcode != HLT.
  - OP_FETCH: rd if ALUOP.
  - ALU_OP: rd if ALUOP; inc_pc if SKZ and zero; ld_pc if JMP; data_e if STO.
  - STORE: rd and ld_ac if ALUOP; ld_pc and inc_pc if JMP; wr and data_e if STO.
- HLT handling:
  - In OP_ADDR with opcode=HLT and en_cpu=1, the next edge sets halt=1 and the phase stays at 4.
  - While halt=1, every strobe is forced to 0 and the phase is frozen.
  - Only reset or load_in clears halt.
- Priority, highest first: reset > load_in > halt > en_cpu=0 > normal advance.
- load_in=1: on each edge phase<=0 and halt<=0. All strobes are forced to 0 while load_in is high, including sel, so the loader owns the bus.
- en_cpu=0: phase holds and all strobes are forced to 0.

## Timing
- Reset values: phase=0, halt=0, instr_done=0.
- Strobes during reset: all 0, because the reset gating forces them low.
- One phase per clock; one instruction takes 8 cycles.
- Strobes are valid within the same cycle as their phase, with no added latency.
- opcode is sampled live. It must be stable from IDLE through STORE. ld_ir in INST_LOAD/IDLE updates it before OP_ADDR.
- instr_done is high only in STORE, on a cycle where the phase will advance.
- Reset mid-instruction: phase returns to 0 immediately (asynchronous). Partial instructions are not replayed.
- load_in dropping: execution starts at INST_ADDR on the first edge with load_in=0 and en_cpu=1.
- SKZ with zero=1: inc_pc fires in both OP_ADDR and ALU_OP, so the PC advances by 2 in total.

## Configuration
- CPU_SEQ_STEP_EN defined:
  - The step port exists.
  - The transition INST_ADDR->INST_FETCH occurs only on an edge where step=1.
  - All other phases advance freely.
  - While waiting at INST_ADDR, sel=1 and all other strobes are 0.
- CPU_SEQ_STEP_EN undefined: no step port; INST_ADDR advances unconditionally.

## Structure
- Package cpu_pkg holds:
  - opcode localparams (OP_HLT..OP_JMP);
  - phase localparams (PH_INST_ADDR..PH_STORE);
  - strobe bundle typedef.
- Sub-module cpu_seq_decode: purely combinational. It maps phase, opcode and zero to the strobe bundle.
- The top level holds the phase counter, the halt flag, the gating logic and instr_done.

## Test plan
- Reset asserted mid-phase 5 -> phase=0, halt=0, all strobes 0 immediately; after release, sel=1 in phase 0.
- ADD, en_cpu=1 -> across 8 cycles: rd=1 in phases 1–3 and 5–7; ld_ir=1 in phases 2–3; inc_pc only in phase 4; ld_ac only in phase 7; instr_done in phase 7.
- SKZ with zero=1 -> inc_pc in phases 4 and 6. SKZ with zero=0 -> inc_pc only in phase 4.
- STO -> data_e in phases 6–7, wr only in phase 7. JMP -> ld_pc in phases 6–7, inc_pc in phases 4 and 7.
- HLT -> halt=1 after the phase-4 edge; the phase stays 4 for 20 cycles with zero strobes; a load_in pulse gives phase=0, halt=0.
- en_cpu=0 for 3 cycles at phase 2 -> phase holds at 2 with strobes 0, then resumes at phase 3. With CPU_SEQ_STEP_EN: holds at phase 0 until step=1.
